aidan_mcnay_prime_seq: RTL and testbench

Trial-division sequencer that sits directly upstream of the iterative remainder unit. It accepts one candidate N, then issues (N, d) pairs to the divider for d = 2, 3, ... while d*d <= N. It consumes each remainder and reports whether N is prime, together with the smallest factor found.

---
 rtl/aidan_mcnay_prime_seq.sv | 85 ++++++++
 tb/tb_aidan_mcnay_prime_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/aidan_mcnay_prime_seq.sv
// aidan_mcnay_prime_seq: trial-division sequencer feeding an iterative remainder unit
// Define PRIME_SEQ_ODD_SKIP_EN to try only odd divisors after d=2.
module aidan_mcnay_prime_seq #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             istream_val,
  output logic             istream_rdy,
  input  logic [nbits-1:0] istream_num,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic             ostream_prime,
  output logic [nbits-1:0] ostream_factor,
  output logic [nbits-1:0] div_opa,
  output logic [nbits-1:0] div_opb,
  output logic             div_istream_val,
  input  logic             div_istream_rdy,
  input  logic [nbits-1:0] div_result,
  input  logic             div_ostream_val,
  output logic             div_ostream_rdy
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} state_t;
  state_t state, state_next;
  logic [nbits-1:0] n, d, d_step;
  logic [2*nbits-1:0] d_sq;
  logic too_small, past_root, hit;
  assign d_sq      = {{nbits{1'b0}}, d} * {{nbits{1'b0}}, d};
  assign too_small = n < nbits'(2);
  assign past_root = d_sq > {{nbits{1'b0}}, n};
  assign hit       = div_result == '0;
`ifdef PRIME_SEQ_ODD_SKIP_EN
  assign d_step = (d == nbits'(2)) ? nbits'(3) : d + nbits'(2);
`else
  assign d_step = d + nbits'(1);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = istream_val ? CHECK : IDLE;
      CHECK:   state_next = (too_small || past_root) ? DONE : ISSUE;
      ISSUE:   state_next = div_istream_rdy ? WAIT : ISSUE;
      WAIT:    state_next = !div_ostream_val ? WAIT : hit ? DONE : CHECK;
      DONE:    state_next = ostream_rdy ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    istream_rdy     = state == IDLE;
    div_istream_val = state == ISSUE;
    div_ostream_rdy = state == WAIT;
    ostream_val     = state == DONE;
    div_opa         = n;
    div_opb         = d;
  end
  // Verdict registers only change on CHECK/WAIT decisions, so they hold through DONE and after.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      n              <= '0;
      d              <= nbits'(2);
      ostream_prime  <= 1'b0;
      ostream_factor <= '0;
    end else begin
      case (state)
        IDLE: if (istream_val) begin
          n <= istream_num;
          d <= nbits'(2);
        end
        CHECK: if (too_small || past_root) begin
          ostream_prime  <= !too_small;
          ostream_factor <= '0;
        end
        WAIT: if (div_ostream_val) begin
          if (hit) begin
            ostream_prime  <= 1'b0;
            ostream_factor <= d;
          end else d <= d_step;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_aidan_mcnay_prime_seq.sv
// tb_aidan_mcnay_prime_seq: directed test of the prime sequencer against a stalling divider model
module tb_aidan_mcnay_prime_seq;
  logic clk, reset;
  logic istream_val, istream_rdy, ostream_val, ostream_rdy, ostream_prime;
  logic [15:0] istream_num, ostream_factor, div_opa, div_opb, div_result;
  logic div_istream_val, div_istream_rdy, div_ostream_val, div_ostream_rdy;
  int n_checks, n_fail;
  logic [15:0] issued[$];
  logic [15:0] ra, rb;
  bit phase, iss_fire, rsp_fire;
  int cyc;
`ifdef PRIME_SEQ_ODD_SKIP_EN
  localparam int T97 = 5, T65521 = 128, T91 = 4;
`else
  localparam int T97 = 8, T65521 = 254, T91 = 6;
`endif

  aidan_mcnay_prime_seq #(.nbits(16)) dut (
    .clk(clk), .reset(reset),
    .istream_val(istream_val), .istream_rdy(istream_rdy), .istream_num(istream_num),
    .ostream_val(ostream_val), .ostream_rdy(ostream_rdy),
    .ostream_prime(ostream_prime), .ostream_factor(ostream_factor),
    .div_opa(div_opa), .div_opb(div_opb),
    .div_istream_val(div_istream_val), .div_istream_rdy(div_istream_rdy),
    .div_result(div_result), .div_ostream_val(div_ostream_val), .div_ostream_rdy(div_ostream_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Divider model: accepts with stalls, answers N mod d a cycle or two later.
  initial begin
    div_istream_rdy = 1'b0; div_ostream_val = 1'b0; div_result = '0;
    phase = 0; iss_fire = 0; rsp_fire = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin phase = 0; iss_fire = 0; rsp_fire = 0; end
      if (iss_fire) phase = 1;
      if (rsp_fire) phase = 0;
      div_istream_rdy = !reset && !phase && (cyc % 3 != 0);
      div_ostream_val = !reset && phase && (cyc % 2 == 0);
      div_result = div_ostream_val ? ra % rb : 16'h0000;
      iss_fire = div_istream_val && div_istream_rdy;
      if (iss_fire) begin ra = div_opa; rb = div_opb; issued.push_back(div_opb); end
      rsp_fire = div_ostream_val && div_ostream_rdy;
    end
  end

  task automatic run(input logic [15:0] num, input logic exp_prime, input logic [15:0] exp_factor,
                     input int exp_trans, input int exp_lat, input int hold);
    int t, lat;
    issued.delete();
    t = 0;
    while (!istream_rdy && t < 100) begin @(negedge clk); t++; end
    check("accept_rdy", istream_rdy, 1);
    istream_val = 1'b1; istream_num = num;
    @(negedge clk);
    istream_val = 1'b0; lat = 1;
    while (!ostream_val && lat < 5000) begin @(negedge clk); lat++; end
    check("verdict_val", ostream_val, 1);
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check("prime", ostream_prime, exp_prime);
    check("factor", ostream_factor, exp_factor);
    check("ntrans", issued.size(), exp_trans);
    check("in_rdy_done", istream_rdy, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_val", ostream_val, 1);
      check("hold_prime", ostream_prime, exp_prime);
      check("hold_factor", ostream_factor, exp_factor);
    end
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
    check("val_drop", ostream_val, 0);
    check("idle_rdy", istream_rdy, 1);
  endtask

  initial begin
    int t;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; istream_val = 1'b0; istream_num = '0; ostream_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_rdy", istream_rdy, 1);
    check("rst_out_val", ostream_val, 0);
    check("rst_div_val", div_istream_val, 0);
    check("rst_div_rdy", div_ostream_rdy, 0);
    check("rst_prime", ostream_prime, 0);
    check("rst_factor", ostream_factor, 0);
    check("rst_d", div_opb, 2);
    reset = 1'b0;
    @(negedge clk);
    run(16'd0, 0, 0, 0, -1, 0);
    run(16'd1, 0, 0, 0, -1, 0);
    run(16'd2, 1, 0, 0, 2, 0);
    run(16'd3, 1, 0, 0, 2, 0);
    run(16'd9, 0, 3, 2, -1, 0);
    check("n9_d0", issued[0], 2);
    check("n9_d1", issued[1], 3);
    run(16'd97, 1, 0, T97, -1, 0);
    check("n97_last_d", issued[$], 9);
    run(16'd65521, 1, 0, T65521, -1, 10);
    check("n65521_last_d", issued[$], 255);
    // Abort a candidate while the sequencer waits on a remainder.
    istream_val = 1'b1; istream_num = 16'd91;
    @(negedge clk);
    istream_val = 1'b0;
    t = 0;
    while (!div_ostream_rdy && t < 200) begin @(negedge clk); t++; end
    check("reach_wait", div_ostream_rdy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_in_rdy", istream_rdy, 1);
    check("mid_out_val", ostream_val, 0);
    check("mid_div_val", div_istream_val, 0);
    check("mid_div_rdy", div_ostream_rdy, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    run(16'd91, 0, 7, T91, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
